// File: rtl/input_pulse_meter_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : input_pulse_meter_pkg
// Purpose  : Shared definitions for the pulse meter: FSM state encoding,
//            counter width and the saturation value of the length counter.
// Ports    : none (package)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
package input_pulse_meter_pkg;

   localparam int CNT_W = 32;

   // All-ones is the saturation value of the length counter
   localparam logic [CNT_W-1:0] c_cnt_max  = '1;
   localparam logic [CNT_W-1:0] c_cnt_near = c_cnt_max - 1'b1;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      MEAS = 1'b1
   } state_t;

endpackage
`default_nettype wire

// File: rtl/input_pulse_meter_sync.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : input_sync
// Purpose  : Multi-flop synchronizer bringing an asynchronous level into the
//            Clock domain. Generic so other input blocks can reuse it.
// Ports    : Clock - rising-edge clock
//            Reset - asynchronous active-low reset, clears all stages
//            d     - asynchronous input
//            q     - synchronized output (last stage)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module input_sync #(
   parameter int STAGES = 2
) (
   input  logic Clock,
   input  logic Reset,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] r_sync;

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[STAGES-2:0], d};
      end
   end

   assign q = r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/input_pulse_meter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : input_pulse_meter
// Purpose  : Measures the high-time of an asynchronous pulse in Clock cycles.
//            Pulses shorter than MIN_LEN are rejected and flagged as glitches.
// Ports    : Clock    - rising-edge clock
//            Reset    - asynchronous active-low reset
//            in       - asynchronous pulse input, active-high
//            length   - high-time of the last accepted pulse
//            valid    - one-cycle strobe, length has just been updated
//            overflow - last accepted pulse saturated the counter
//            glitch   - one-cycle strobe, a too-short pulse was rejected
//            busy     - a pulse is currently being measured
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module input_pulse_meter
   import input_pulse_meter_pkg::*;
#(
   parameter int          SYNC_STAGES = 2,
   parameter int unsigned MIN_LEN     = 1
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             in,
   output logic [CNT_W-1:0] length,
   output logic             valid,
   output logic             overflow,
   output logic             glitch,
   output logic             busy
);

   localparam logic [CNT_W-1:0] c_min_len = CNT_W'(MIN_LEN);

   logic             w_s;
   logic             w_rise;
   logic             w_fall;
   logic             r_s_d;
   state_t           r_state;
   logic [CNT_W-1:0] r_count;
   logic             r_sat;
   logic [CNT_W-1:0] r_length;
   logic             r_overflow;
   logic             r_valid;
   logic             r_glitch;

   input_sync #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .Clock (Clock),
      .Reset (Reset),
      .d     (in),
      .q     (w_s)
   );

   assign w_rise =  w_s & ~r_s_d;
   assign w_fall = ~w_s &  r_s_d;

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         r_s_d      <= 1'b0;
         r_state    <= IDLE;
         r_count    <= '0;
         r_sat      <= 1'b0;
         r_length   <= '0;
         r_overflow <= 1'b0;
         r_valid    <= 1'b0;
         r_glitch   <= 1'b0;
      end else begin
         r_s_d    <= w_s;
         r_valid  <= 1'b0;
         r_glitch <= 1'b0;
         case (r_state)
            IDLE: begin
               // The rise cycle itself is the first high cycle of the pulse
               if (w_rise) begin
                  r_count <= CNT_W'(1);
                  r_sat   <= 1'b0;
                  r_state <= MEAS;
               end
            end
            MEAS: begin
               if (w_s) begin
                  if (r_count != c_cnt_max) begin
                     r_count <= r_count + 1'b1;
                     if (r_count == c_cnt_near) begin
                        r_sat <= 1'b1;
                     end
                  end else begin
                     r_sat <= 1'b1;
                  end
               end else begin
                  // s low in MEAS is always a fall since s_d was high
                  if (w_fall) begin
                     if (r_count >= c_min_len) begin
                        r_length   <= r_count;
                        r_overflow <= r_sat;
                        r_valid    <= 1'b1;
                     end else begin
                        r_glitch   <= 1'b1;
                     end
                  end
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign length   = r_length;
   assign valid    = r_valid;
   assign overflow = r_overflow;
   assign glitch   = r_glitch;
   assign busy     = (r_state == MEAS);

endmodule
`default_nettype wire

// File: doc/input_pulse_meter.md
INPUT_PULSE_METER -- requirements
Module: input_pulse_meter

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, meaning the number of synchronizer flops on in (legal values 2..4).
REQ-002 The block SHALL have parameter MIN_LEN, default 1, meaning the minimum accepted pulse length in Clock cycles (legal values 1..2^32-1).
REQ-003 The block SHALL have port Clock, input, 1 bit: the rising-edge clock.
REQ-004 The block SHALL have port Reset, input, 1 bit: the reset, asynchronous, active-low.
REQ-005 The block SHALL have port in, input, 1 bit: the asynchronous pulse to be measured, active-high.
REQ-006 The block SHALL have port length, output, 32 bits: the high-time of the last accepted pulse, in Clock cycles.
REQ-007 The block SHALL have port valid, output, 1 bit: a one-cycle strobe meaning length has just been updated.
REQ-008 The block SHALL have port overflow, output, 1 bit: set together with valid when the last accepted pulse saturated the counter.
REQ-009 The block SHALL have port glitch, output, 1 bit: a one-cycle strobe meaning a pulse shorter than MIN_LEN was rejected.
REQ-010 The block SHALL have port busy, output, 1 bit: high while a pulse is being measured.

Function
REQ-011 The block SHALL pass in through SYNC_STAGES flops to produce s, and register s to produce s_d; all decisions SHALL use s and s_d only.
REQ-012 The rise condition SHALL be s=1 and s_d=0; the fall condition SHALL be s=0 and s_d=1.
REQ-013 The FSM SHALL have two states, IDLE and MEAS; the reset state SHALL be IDLE.
REQ-014 In IDLE, the rise condition SHALL load count with 1 and move the FSM to MEAS.
REQ-015 In MEAS with s=1, count SHALL increment by 1 per cycle and SHALL saturate at 32'hFFFF_FFFF; reaching saturation SHALL set a sticky sat flag.
REQ-016 In MEAS, the fall condition with count >= MIN_LEN SHALL set length <= count, overflow <= sat and valid <= 1 for exactly one cycle, then move the FSM to IDLE.
REQ-017 In MEAS, the fall condition with count < MIN_LEN SHALL set glitch <= 1 for one cycle, leave length and overflow unchanged, and move the FSM to IDLE.
REQ-018 A pulse sampled high at exactly L consecutive Clock edges SHALL report length = L, or 32'hFFFF_FFFF with overflow=1 if L >= 2^32-1.
REQ-019 valid (or glitch) SHALL assert after the (SYNC_STAGES+1)-th rising Clock edge at which in is sampled low.
REQ-020 busy SHALL equal (state == MEAS).
REQ-021 A rise condition in the cycle directly after a fall (gap of one low cycle) SHALL start a new measurement; no pulse SHALL be lost.
REQ-022 length and overflow SHALL hold their values until the next accepted pulse.
REQ-023 valid and glitch SHALL never be high in the same cycle.

Reset
REQ-024 Asserting Reset low SHALL immediately clear the sync flops, s_d, count, sat, length, overflow, valid and glitch to 0, and set the state to IDLE.
REQ-025 A Reset in the middle of a pulse SHALL discard that pulse; if in is still high when Reset releases, a rise condition SHALL be detected and a new measurement SHALL start.

Structure
REQ-026 A shared package SHALL hold the state encoding (IDLE=0, MEAS=1) and the constant CNT_W=32.
REQ-027 The synchronizer SHALL be a sub-module input_sync (parameter STAGES, ports Clock, Reset, d, q), reusable by other input blocks.

Verification
REQ-028 Reset release; in high for 10 cycles -> length=10, valid one cycle at low-sample edge 3, overflow=0.
REQ-029 MIN_LEN=4; in high for 3 cycles -> glitch one cycle, length unchanged, valid stays 0; then a 5-cycle pulse -> length=5, valid=1.
REQ-030 Pulses of 1 and 2 cycles separated by one low cycle -> two valid strobes, length=1 then length=2.
REQ-031 Counter preset by force to 32'hFFFF_FFFD during a pulse, held high 5 more cycles -> length=32'hFFFF_FFFF, overflow=1.
REQ-032 Reset asserted at cycle 4 of a 20-cycle pulse and released at cycle 8 -> no valid during reset; after release, valid with length=12 (cycles from the new rise detection to the fall).
REQ-033 in toggling asynchronously to Clock (random phase) -> reported length within ±1 of the true high-time, busy consistent with the FSM state.
